// File: rtl/priority_intr_controller_if.sv
// Memory-mapped slave bus for the priority interrupt controller.
// data_bus and fc_bus are tri-stated by whichever side is currently driving them.
interface priority_intr_controller_if;
    logic [31:0] addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;
    wire         fc_bus;

    modport master (
        output addr_bus, rd_bus, wr_bus, data_mask_bus,
        inout  data_bus,
        input  fc_bus
    );

    modport slave (
        input  addr_bus, rd_bus, wr_bus, data_mask_bus,
        inout  data_bus,
        output fc_bus
    );
endinterface

// File: rtl/priority_intr_controller.sv
// Priority interrupt controller: per-source priority, edge/level trigger, threshold,
// and claim/complete with in-service tracking, exposed as a memory-mapped bus slave.
module priority_intr_controller #(
    parameter int NUM_SOURCES = 16,
    parameter int PRIO_BITS   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    priority_intr_controller_if.slave  bus,
    input  logic [NUM_SOURCES-1:0]     intr_reqs,
    output logic                       has_req
);
    localparam logic [31:0] ADDR_PENDING = 32'h00;
    localparam logic [31:0] ADDR_ENABLE  = 32'h04;
    localparam logic [31:0] ADDR_MODE    = 32'h08;
    localparam logic [31:0] ADDR_THRESH  = 32'h0C;
    localparam logic [31:0] ADDR_CLAIM   = 32'h10;
    localparam logic [31:0] ADDR_INSERV  = 32'h14;
    localparam logic [31:0] ADDR_PRIO    = 32'h20;
    localparam logic [31:0] PRIO_END     = 32'h20 + 32'(4 * NUM_SOURCES);

    logic [NUM_SOURCES-1:0] pending, enable, mode, in_service, prev_req;
    logic [NUM_SOURCES-1:0] pending_n, in_service_n, eligible, set_req, clr_req;
    logic [PRIO_BITS-1:0]   prio [NUM_SOURCES];
    logic [PRIO_BITS-1:0]   threshold, best_prio;
    logic [4:0]             winner, prio_idx;
    logic                   any_elig, claim_busy, wr_done;
    logic [31:0]            claim_id, claim_value, rdata;

    logic [31:0] base, wdata, be_mask, prio_off;
    logic [1:0]  offset;
    logic        rd_valid, wr_valid, hit, addressed_rd, addressed_wr, wr_fire;
    logic        sel_pending, sel_enable, sel_mode, sel_thresh, sel_claim, sel_inserv, sel_prio;
    logic        sel_claim_rd, claim_fire, complete_ok;
    logic        unused_bits;

    function automatic logic [31:0] expand_be(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [NUM_SOURCES-1:0] merge_src(input logic [NUM_SOURCES-1:0] old,
                                                          input logic [NUM_SOURCES-1:0] nv,
                                                          input logic [NUM_SOURCES-1:0] m);
        return (old & ~m) | (nv & m);
    endfunction

    function automatic logic [PRIO_BITS-1:0] merge_prio(input logic [PRIO_BITS-1:0] old,
                                                         input logic [PRIO_BITS-1:0] nv,
                                                         input logic [PRIO_BITS-1:0] m);
        return (old & ~m) | (nv & m);
    endfunction

    assign base     = {bus.addr_bus[31:2], 2'b00};
    assign offset   = bus.addr_bus[1:0];
    assign wdata    = bus.data_bus;
    assign be_mask  = expand_be(bus.data_mask_bus);
    assign prio_off = base - ADDR_PRIO;
    assign prio_idx = prio_off[6:2];
    assign rd_valid = bus.rd_bus & ~bus.wr_bus;
    assign wr_valid = bus.wr_bus & ~bus.rd_bus;

    assign sel_pending = (base == ADDR_PENDING);
    assign sel_enable  = (base == ADDR_ENABLE);
    assign sel_mode    = (base == ADDR_MODE);
    assign sel_thresh  = (base == ADDR_THRESH);
    assign sel_claim   = (base == ADDR_CLAIM);
    assign sel_inserv  = (base == ADDR_INSERV);
    assign sel_prio    = (base >= ADDR_PRIO) && (base < PRIO_END);
    assign hit = sel_pending | sel_enable | sel_mode | sel_thresh | sel_claim | sel_inserv | sel_prio;

    assign addressed_rd = rd_valid & hit;
    assign addressed_wr = wr_valid & hit;
    assign wr_fire      = addressed_wr & ~wr_done;
    assign sel_claim_rd = rd_valid & sel_claim;
    assign claim_fire   = sel_claim_rd & ~claim_busy & any_elig;
    assign complete_ok  = wr_fire & sel_claim & (32'(wdata[4:0]) < 32'(NUM_SOURCES));
    assign unused_bits  = ^{wdata, be_mask, prio_off};

    // Arbitration: strict '>' keeps the lowest index on equal priority.
    always_comb begin
        eligible  = '0;
        any_elig  = 1'b0;
        winner    = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            eligible[i] = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
            if (eligible[i] && (!any_elig || prio[i] > best_prio)) begin
                any_elig  = 1'b1;
                winner    = 5'(i);
                best_prio = prio[i];
            end
        end
    end

    assign has_req     = any_elig;
    assign claim_value = any_elig ? 32'(winner) : 32'hFFFF_FFFF;

    // Set beats clear, so a request arriving with a W1C or claim keeps the bit.
    always_comb begin
        set_req      = intr_reqs & enable & (~mode | ~prev_req);
        clr_req      = '0;
        in_service_n = in_service;
        if (wr_fire && sel_pending)
            clr_req = wdata[NUM_SOURCES-1:0] & be_mask[NUM_SOURCES-1:0];
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (claim_fire && winner == 5'(i)) begin
                clr_req[i]      = 1'b1;
                in_service_n[i] = 1'b1;
            end
            if (complete_ok && wdata[4:0] == 5'(i))
                in_service_n[i] = 1'b0;
        end
        pending_n = set_req | (pending & ~clr_req);
    end

    always_comb begin
        rdata = '0;
        if (sel_pending) rdata = 32'(pending);
        if (sel_enable)  rdata = 32'(enable);
        if (sel_mode)    rdata = 32'(mode);
        if (sel_thresh)  rdata = 32'(threshold);
        if (sel_claim)   rdata = claim_busy ? claim_id : claim_value;
        if (sel_inserv)  rdata = 32'(in_service);
        for (int i = 0; i < NUM_SOURCES; i++)
            if (sel_prio && prio_idx == 5'(i)) rdata = 32'(prio[i]);
    end

    assign bus.data_bus = addressed_rd ? (rdata >> {offset, 3'b000}) : 'z;
    assign bus.fc_bus   = addressed_rd ? 1'b1 : (addressed_wr ? wr_done : 1'bz);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
            in_service <= '0;
            prev_req   <= '0;
            threshold  <= '0;
            claim_busy <= 1'b0;
            wr_done    <= 1'b0;
            for (int i = 0; i < NUM_SOURCES; i++) prio[i] <= PRIO_BITS'(1);
        end else begin
            prev_req   <= intr_reqs;
            pending    <= pending_n;
            in_service <= in_service_n;
            claim_busy <= sel_claim_rd;
            wr_done    <= addressed_wr;
            if (wr_fire && sel_enable)
                enable <= merge_src(enable, wdata[NUM_SOURCES-1:0], be_mask[NUM_SOURCES-1:0]);
            if (wr_fire && sel_mode)
                mode <= merge_src(mode, wdata[NUM_SOURCES-1:0], be_mask[NUM_SOURCES-1:0]);
            if (wr_fire && sel_thresh)
                threshold <= merge_prio(threshold, wdata[PRIO_BITS-1:0], be_mask[PRIO_BITS-1:0]);
            for (int i = 0; i < NUM_SOURCES; i++)
                if (wr_fire && sel_prio && prio_idx == 5'(i))
                    prio[i] <= merge_prio(prio[i], wdata[PRIO_BITS-1:0], be_mask[PRIO_BITS-1:0]);
        end
    end

    // Latched on the first claim cycle so a held read keeps returning the same id.
    always_ff @(posedge clk) begin
        if (sel_claim_rd && !claim_busy) claim_id <= claim_value;
    end
endmodule

// File: tb/tb_priority_intr_controller.sv
// Directed bench for priority_intr_controller with hand-computed expectations.
module tb_priority_intr_controller;
    localparam int N = 16;
    localparam int P = 3;

    localparam logic [31:0] A_PEND  = 32'h00;
    localparam logic [31:0] A_EN    = 32'h04;
    localparam logic [31:0] A_MODE  = 32'h08;
    localparam logic [31:0] A_THR   = 32'h0C;
    localparam logic [31:0] A_CLAIM = 32'h10;
    localparam logic [31:0] A_INS   = 32'h14;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  intr_reqs;
    logic          has_req;
    logic          drv_en;
    logic [31:0]   drv_data;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    priority_intr_controller_if bus ();
    assign bus.data_bus = drv_en ? drv_data : 'z;

    priority_intr_controller #(.NUM_SOURCES(N), .PRIO_BITS(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .intr_reqs (intr_reqs),
        .has_req   (has_req)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic fc);
        bus.addr_bus = a;
        bus.rd_bus   = 1'b1;
        #1;
        d  = bus.data_bus;
        fc = (bus.fc_bus === 1'b1);
        @(negedge clk);
        bus.rd_bus = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        fc;
        bus_rd(a, d, fc);
        chk(tag, d, exp);
        chk({tag, "_fc"}, {31'b0, fc}, 32'd1);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m = 4'hF);
        bus.addr_bus      = a;
        bus.data_mask_bus = m;
        drv_data          = d;
        drv_en            = 1'b1;
        bus.wr_bus        = 1'b1;
        @(negedge clk);
        chk("wr_fc", {31'b0, bus.fc_bus === 1'b1}, 32'd1);
        bus.wr_bus = 1'b0;
        drv_en     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        fc;
        rst = 1'b1;
        intr_reqs = '0;
        drv_en = 1'b0;
        drv_data = '0;
        bus.addr_bus = '0;
        bus.rd_bus = 1'b0;
        bus.wr_bus = 1'b0;
        bus.data_mask_bus = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_has_req", {31'b0, has_req}, 32'd0);
        chk("rst_fc_idle", {31'b0, bus.fc_bus === 1'b1}, 32'd0);
        rd_chk("rst_pend", A_PEND, 32'h0);
        rd_chk("rst_en", A_EN, 32'h0);
        rd_chk("rst_mode", A_MODE, 32'h0);
        rd_chk("rst_thr", A_THR, 32'h0);
        rd_chk("rst_ins", A_INS, 32'h0);
        rd_chk("rst_prio5", 32'h34, 32'h1);
        rd_chk("rst_claim", A_CLAIM, 32'hFFFF_FFFF);

        // Byte-enable merge, offset read, unmapped address
        bus_wr(A_EN, 32'h0000_ABCD, 4'b0011);
        bus_wr(A_EN, 32'h0000_0012, 4'b0001);
        rd_chk("en_merge", A_EN, 32'h0000_AB12);
        rd_chk("en_off1", 32'h05, 32'h0000_00AB);
        bus_rd(32'h18, d, fc);
        chk("unmapped_fc", {31'b0, fc}, 32'd0);
        bus_rd(32'h60, d, fc);
        chk("prio16_fc", {31'b0, fc}, 32'd0);

        // Edge on source 0, claim, complete
        bus_wr(A_EN, 32'h1);
        bus_wr(A_MODE, 32'h1);
        intr_reqs = 16'h0001;
        @(negedge clk);
        intr_reqs = '0;
        chk("t1_has_req", {31'b0, has_req}, 32'd1);
        rd_chk("t1_pend", A_PEND, 32'h1);
        rd_chk("t1_claim", A_CLAIM, 32'h0);
        rd_chk("t1_pend_clr", A_PEND, 32'h0);
        rd_chk("t1_ins", A_INS, 32'h1);
        chk("t1_has_req_off", {31'b0, has_req}, 32'd0);
        bus_wr(A_CLAIM, 32'h0);
        rd_chk("t1_ins_done", A_INS, 32'h0);

        // Level sources 2,3,7 arbitrated by priority then index
        bus_wr(32'h2C, 32'h5);
        bus_wr(32'h3C, 32'h5);
        bus_wr(32'h28, 32'h6);
        bus_wr(A_EN, 32'hFFFF);
        bus_wr(A_MODE, 32'h0);
        intr_reqs = 16'h008C;
        @(negedge clk);
        rd_chk("t2_claim_a", A_CLAIM, 32'd2);
        rd_chk("t2_claim_b", A_CLAIM, 32'd3);
        rd_chk("t2_claim_c", A_CLAIM, 32'd7);
        rd_chk("t2_claim_none", A_CLAIM, 32'hFFFF_FFFF);
        rd_chk("t2_ins", A_INS, 32'h8C);
        chk("t2_has_req_off", {31'b0, has_req}, 32'd0);
        bus_wr(A_CLAIM, 32'd3);
        chk("t2_repend", {31'b0, has_req}, 32'd1);
        rd_chk("t2_reclaim", A_CLAIM, 32'd3);
        bus_wr(A_CLAIM, 32'd2);
        bus_wr(A_CLAIM, 32'd3);
        bus_wr(A_CLAIM, 32'd7);
        intr_reqs = '0;
        @(negedge clk);
        bus_wr(A_PEND, 32'hFFFF);
        rd_chk("t2_pend_clr", A_PEND, 32'h0);

        // Threshold masking, then priority 0 never interrupts
        bus_wr(A_THR, 32'h5);
        intr_reqs = 16'h0008;
        @(negedge clk);
        chk("t3_thr_mask", {31'b0, has_req}, 32'd0);
        rd_chk("t3_claim_none", A_CLAIM, 32'hFFFF_FFFF);
        rd_chk("t3_pend", A_PEND, 32'h8);
        bus_wr(A_THR, 32'h4);
        chk("t3_thr_pass", {31'b0, has_req}, 32'd1);
        rd_chk("t3_claim", A_CLAIM, 32'd3);
        bus_wr(A_CLAIM, 32'd3);
        intr_reqs = '0;
        @(negedge clk);
        bus_wr(A_PEND, 32'hFFFF);
        bus_wr(A_THR, 32'h0);
        bus_wr(32'h44, 32'h0);
        intr_reqs = 16'h0200;
        @(negedge clk);
        chk("t3_prio0", {31'b0, has_req}, 32'd0);
        rd_chk("t3_prio0_claim", A_CLAIM, 32'hFFFF_FFFF);
        intr_reqs = '0;
        @(negedge clk);
        bus_wr(A_PEND, 32'hFFFF);

        // Edge on source 4 coincides with W1C of bit 4
        bus_wr(A_MODE, 32'h10);
        intr_reqs = 16'h0010;
        bus_wr(A_PEND, 32'h10);
        rd_chk("t4_set_wins", A_PEND, 32'h10);
        bus_wr(A_PEND, 32'h10);
        rd_chk("t4_w1c", A_PEND, 32'h0);
        intr_reqs = '0;
        @(negedge clk);

        // Held claim read returns a stable id and claims once
        bus_wr(A_MODE, 32'h0);
        intr_reqs = 16'h0040;
        @(negedge clk);
        bus.addr_bus = A_CLAIM;
        bus.rd_bus   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t5_hold%0d", k), bus.data_bus, 32'd6);
            @(negedge clk);
        end
        bus.rd_bus = 1'b0;
        chk("t5_has_req_off", {31'b0, has_req}, 32'd0);
        @(negedge clk);
        rd_chk("t5_ins", A_INS, 32'h40);

        // Complete with an out-of-range id still handshakes
        bus.addr_bus      = A_CLAIM;
        bus.data_mask_bus = 4'hF;
        drv_data          = 32'd31;
        drv_en            = 1'b1;
        bus.wr_bus        = 1'b1;
        #1;
        chk("t5_fc_first", {31'b0, bus.fc_bus === 1'b1}, 32'd0);
        @(negedge clk);
        chk("t5_fc_second", {31'b0, bus.fc_bus === 1'b1}, 32'd1);
        bus.wr_bus = 1'b0;
        drv_en     = 1'b0;
        @(negedge clk);
        rd_chk("t5_ins_kept", A_INS, 32'h40);
        bus_wr(A_CLAIM, 32'd6);
        intr_reqs = '0;
        @(negedge clk);
        bus_wr(A_PEND, 32'hFFFF);

        // Reset in the middle of a write
        intr_reqs = 16'h0001;
        @(negedge clk);
        rd_chk("t6_claim", A_CLAIM, 32'd0);
        bus_wr(A_THR, 32'h2);
        bus_wr(A_MODE, 32'h2);
        bus.addr_bus      = A_EN;
        bus.data_mask_bus = 4'hF;
        drv_data          = 32'h1234;
        drv_en            = 1'b1;
        bus.wr_bus        = 1'b1;
        rst               = 1'b1;
        intr_reqs         = '0;
        @(negedge clk);
        rst        = 1'b0;
        bus.wr_bus = 1'b0;
        drv_en     = 1'b0;
        @(negedge clk);
        chk("t6_fc_idle", {31'b0, bus.fc_bus === 1'b1}, 32'd0);
        chk("t6_has_req", {31'b0, has_req}, 32'd0);
        rd_chk("t6_en", A_EN, 32'h0);
        rd_chk("t6_mode", A_MODE, 32'h0);
        rd_chk("t6_thr", A_THR, 32'h0);
        rd_chk("t6_ins", A_INS, 32'h0);
        rd_chk("t6_pend", A_PEND, 32'h0);
        rd_chk("t6_prio2", 32'h28, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
